// File: rtl/adc_emu_pkg.sv
// Shared types and constants for the Stonyman + serial ADC emulator.
package adc_emu_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_DOT   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StTail  = 2'd2
  } state_e;

  localparam int unsigned LEAD_BITS  = 4;
  localparam int unsigned DATA_BITS  = 12;
  localparam int unsigned FRAME_BITS = LEAD_BITS + DATA_BITS;

  localparam logic [DATA_BITS-1:0] BLANK_PIXEL   = 12'h000;
  localparam logic [DATA_BITS-1:0] CHECK_HI      = 12'hFFF;
  localparam logic [DATA_BITS-1:0] DOT_IN_LEVEL  = 12'h100;
  localparam logic [DATA_BITS-1:0] DOT_OUT_LEVEL = 12'hC00;

endpackage

// File: rtl/adc_emu_pattern.sv
// Combinational test-pattern generator: pointers + mode -> 12-bit pixel value.
module adc_emu_pattern
  import adc_emu_pkg::*;
#(
  parameter int unsigned IMG_DIM = 112
) (
  input  logic [6:0]           i_row,
  input  logic [6:0]           i_col,
  input  logic [1:0]           i_mode,
  input  logic [DATA_BITS-1:0] i_const_value,
  input  logic [6:0]           i_dot_row,
  input  logic [6:0]           i_dot_col,
  input  logic [13:0]          i_dot_r2,
  output logic [DATA_BITS-1:0] o_value
);

  localparam logic [7:0] DimLim = 8'(IMG_DIM);

  logic signed [7:0] w_dr, w_dc;
  logic [6:0]        w_abs_r, w_abs_c;
  logic [13:0]       w_dr2, w_dc2;
  logic [14:0]       w_dist2;
  logic              w_in_range;

  // Differences stay within +/-127, so magnitudes fit in 7 bits and squares in 14.
  assign w_dr    = {1'b0, i_row} - {1'b0, i_dot_row};
  assign w_dc    = {1'b0, i_col} - {1'b0, i_dot_col};
  assign w_abs_r = w_dr[7] ? 7'(-w_dr) : w_dr[6:0];
  assign w_abs_c = w_dc[7] ? 7'(-w_dc) : w_dc[6:0];
  assign w_dr2   = {7'd0, w_abs_r} * {7'd0, w_abs_r};
  assign w_dc2   = {7'd0, w_abs_c} * {7'd0, w_abs_c};
  assign w_dist2 = {1'b0, w_dr2} + {1'b0, w_dc2};

  assign w_in_range = ({1'b0, i_row} < DimLim) && ({1'b0, i_col} < DimLim);

  always_comb begin
    o_value = BLANK_PIXEL;
    if (w_in_range) begin
      unique case (mode_e'(i_mode))
        MODE_CONST: o_value = i_const_value;
        MODE_RAMP:  o_value = {i_col, 5'b0};
        MODE_CHECK: o_value = (i_row[3] ^ i_col[3]) ? CHECK_HI : BLANK_PIXEL;
        MODE_DOT:   o_value = (w_dist2 < {1'b0, i_dot_r2}) ? DOT_IN_LEVEL : DOT_OUT_LEVEL;
        default:    o_value = BLANK_PIXEL;
      endcase
    end
  end

endmodule

// File: rtl/adc_emulator.sv
// Stonyman sensor + 12-bit serial ADC emulator for one camera channel.
// Define ADC_EMU_NOISE_EN to XOR LFSR noise into the low pixel bits.
module adc_emulator
  import adc_emu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IMG_DIM     = 112,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sclk,
  input  logic        i_cs_n,
  input  logic        i_resp,
  input  logic        i_incp,
  input  logic        i_resv,
  input  logic        i_incv,
  input  logic        i_inphi,
  input  logic [1:0]  i_mode,
  input  logic [11:0] i_const_value,
  input  logic [6:0]  i_dot_row,
  input  logic [6:0]  i_dot_col,
  input  logic [13:0] i_dot_r2,
  output logic        o_sdata,
  output logic        o_sdata_oe,
  output logic [6:0]  o_cur_row,
  output logic [6:0]  o_cur_col,
  output logic [15:0] o_conv_count
);

  localparam int unsigned SclkB = 0;
  localparam int unsigned CsB   = 1;
  localparam int unsigned RespB = 2;
  localparam int unsigned IncpB = 3;
  localparam int unsigned ResvB = 4;
  localparam int unsigned IncvB = 5;

  logic [5:0]                  w_pins, w_lvl, w_rise, w_fall, r_prev;
  logic [SYNC_STAGES-1:0][5:0] r_sync;

  assign w_pins = {i_incv, i_resv, i_incp, i_resp, i_cs_n, i_sclk};

  // Sync chain resets low so a cs_n held low across reset never looks like a fresh fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_pins};
      r_prev <= w_lvl;
    end
  end

  assign w_lvl  = r_sync[SYNC_STAGES-1];
  assign w_rise = w_lvl & ~r_prev;
  assign w_fall = ~w_lvl & r_prev;

  logic [6:0] r_row, r_col;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      if (w_lvl[RespB])      r_col <= '0;
      else if (w_rise[IncpB]) r_col <= r_col + 7'd1;
      if (w_lvl[ResvB])      r_row <= '0;
      else if (w_rise[IncvB]) r_row <= r_row + 7'd1;
    end
  end

  logic [DATA_BITS-1:0] w_pixel, w_value;

  adc_emu_pattern #(
    .IMG_DIM(IMG_DIM)
  ) u_pattern (
    .i_row        (r_row),
    .i_col        (r_col),
    .i_mode       (i_mode),
    .i_const_value(i_const_value),
    .i_dot_row    (i_dot_row),
    .i_dot_col    (i_dot_col),
    .i_dot_r2     (i_dot_r2),
    .o_value      (w_pixel)
  );

  state_e                r_state, w_state_d;
  logic [FRAME_BITS-1:0] r_shift, w_shift_d;
  logic [3:0]            r_bit_cnt, w_bit_cnt_d;
  logic [15:0]           r_conv_count, w_conv_d;
  logic                  w_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_conv_count <= '0;
    end else begin
      r_state      <= w_state_d;
      r_shift      <= w_shift_d;
      r_bit_cnt    <= w_bit_cnt_d;
      r_conv_count <= w_conv_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_bit_cnt_d = r_bit_cnt;
    w_conv_d    = r_conv_count;
    w_start     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_fall[CsB]) begin
          w_state_d   = StShift;
          w_shift_d   = {{LEAD_BITS{1'b0}}, w_value};
          w_bit_cnt_d = '0;
          w_start     = 1'b1;
        end
      end
      StShift: begin
        if (w_rise[CsB]) begin
          w_state_d = StIdle;
        end else if (w_fall[SclkB]) begin
          w_shift_d   = {r_shift[FRAME_BITS-2:0], 1'b0};
          w_bit_cnt_d = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'(FRAME_BITS - 1)) begin
            w_state_d = StTail;
            w_conv_d  = r_conv_count + 16'd1;
          end
        end
      end
      StTail: begin
        if (w_rise[CsB]) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef ADC_EMU_NOISE_EN
  logic [15:0] r_lfsr;

  // Galois form, taps 16,14,13,11; steps once per conversion start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_start) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign w_value = w_pixel ^ {8'h00, r_lfsr[3:0]};

  logic w_unused;
  assign w_unused = i_inphi;
`else
  assign w_value = w_pixel;

  logic w_unused;
  assign w_unused = ^{i_inphi, w_start, LFSR_SEED};
`endif

  assign o_sdata      = (r_state == StShift) & r_shift[FRAME_BITS-1];
  assign o_sdata_oe   = (r_state != StIdle);
  assign o_cur_row    = r_row;
  assign o_cur_col    = r_col;
  assign o_conv_count = r_conv_count;

endmodule

// File: tb/tb_adc_emulator.sv
// Self-checking bench for adc_emulator: directed cases plus randomized conversions vs a model.
module tb_adc_emulator;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0, cs_n = 1'b1;
  logic        resp = 1'b0, incp = 1'b0, resv = 1'b0, incv = 1'b0, inphi = 1'b0;
  logic [1:0]  mode_s = 2'd0;
  logic [11:0] const_value = 12'h000;
  logic [6:0]  dot_row = 7'd0, dot_col = 7'd0;
  logic [13:0] dot_r2 = 14'd0;
  logic        sdata, sdata_oe;
  logic [6:0]  cur_row, cur_col;
  logic [15:0] conv_count;

  always #5 clk = ~clk;

  adc_emulator dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sclk       (sclk),
    .i_cs_n       (cs_n),
    .i_resp       (resp),
    .i_incp       (incp),
    .i_resv       (resv),
    .i_incv       (incv),
    .i_inphi      (inphi),
    .i_mode       (mode_s),
    .i_const_value(const_value),
    .i_dot_row    (dot_row),
    .i_dot_col    (dot_col),
    .i_dot_r2     (dot_r2),
    .o_sdata      (sdata),
    .o_sdata_oe   (sdata_oe),
    .o_cur_row    (cur_row),
    .o_cur_col    (cur_col),
    .o_conv_count (conv_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int m_row = 0, m_col = 0, m_conv = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference pixel: plain integer arithmetic from the pattern rules.
  function automatic int pixel(input int row, input int col, input int mode, input int cval,
                               input int dr, input int dc, input int r2);
    int a, b;
    if (row >= 112 || col >= 112) return 0;
    case (mode)
      0: return cval;
      1: return col * 32;
      2: return (((row / 8) % 2) != ((col / 8) % 2)) ? 'hFFF : 0;
      default: begin
        a = row - dr;
        b = col - dc;
        return (a * a + b * b < r2) ? 'h100 : 'hC00;
      end
    endcase
  endfunction

  // pin: 0 resp, 1 incp, 2 resv, 3 incv
  task automatic pulse(input int pin);
    case (pin)
      0: resp = 1'b1;
      1: incp = 1'b1;
      2: resv = 1'b1;
      default: incv = 1'b1;
    endcase
    tick(HALF);
    case (pin)
      0: resp = 1'b0;
      1: incp = 1'b0;
      2: resv = 1'b0;
      default: incv = 1'b0;
    endcase
    tick(HALF);
    case (pin)
      0: m_col = 0;
      1: m_col = resp ? 0 : (m_col + 1) % 128;
      2: m_row = 0;
      default: m_row = resv ? 0 : (m_row + 1) % 128;
    endcase
  endtask

  task automatic goto_px(input int r, input int c);
    pulse(2);
    pulse(0);
    repeat (r) pulse(3);
    repeat (c) pulse(1);
  endtask

  // Drops cs_n and clocks nfalls sclk falling edges, sampling sdata before each fall.
  task automatic run_conv(input int nfalls, output logic [15:0] word);
    word = '0;
    cs_n = 1'b0;
    tick(HALF);
    for (int k = 0; k < nfalls; k++) begin
      word = {word[14:0], sdata};
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
      tick(HALF);
    end
  endtask

  task automatic conv_check(input string tag, input int exp_val);
    logic [15:0] w;
    run_conv(16, w);
    check_eq(tag, 32'(w), 32'(exp_val));
    check_eq({tag, "_tail_oe"}, 32'(sdata_oe), 32'd1);
    m_conv = (m_conv + 1) % 65536;
    cs_n = 1'b1;
    tick(HALF);
    check_eq({tag, "_cnt"}, 32'(conv_count), 32'(m_conv));
  endtask

  initial begin
    logic [15:0] w;
    int nr, nc, md, ev, nf;

    // Reset state
    #1;
    check_eq("rst_sdata", 32'(sdata), 32'd0);
    check_eq("rst_oe", 32'(sdata_oe), 32'd0);
    check_eq("rst_row", 32'(cur_row), 32'd0);
    check_eq("rst_col", 32'(cur_col), 32'd0);
    check_eq("rst_cnt", 32'(conv_count), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(HALF);

    // Mode 0 conversion and cs_n release latency
    mode_s = 2'd0;
    const_value = 12'hA5C;
    run_conv(16, w);
    check_eq("m0_word", 32'(w), 32'h0A5C);
    check_eq("m0_tail_sdata", 32'(sdata), 32'd0);
    check_eq("m0_cnt", 32'(conv_count), 32'd1);
    m_conv = 1;
    cs_n = 1'b1;
    tick(2);
    check_eq("oe_lat2", 32'(sdata_oe), 32'd1);
    tick(1);
    check_eq("oe_lat3", 32'(sdata_oe), 32'd0);
    tick(HALF);

    // Pointer stepping and ramp pattern
    goto_px(5, 9);
    check_eq("ptr_row", 32'(cur_row), 32'd5);
    check_eq("ptr_col", 32'(cur_col), 32'd9);
    mode_s = 2'd1;
    conv_check("m1", 'h120);

    // Reset level beats increments; 7-bit wrap
    resp = 1'b1;
    pulse(1);
    pulse(1);
    pulse(1);
    check_eq("resp_hold_col", 32'(cur_col), 32'd0);
    resp = 1'b0;
    tick(HALF);
    repeat (127) pulse(1);
    check_eq("col_127", 32'(cur_col), 32'd127);
    pulse(1);
    check_eq("col_wrap", 32'(cur_col), 32'd0);

    // Dot pattern, boundary distance and blank region
    mode_s = 2'd3;
    dot_row = 7'd50;
    dot_col = 7'd50;
    dot_r2 = 14'd100;
    goto_px(52, 53);
    conv_check("dot_in", 'h100);
    goto_px(60, 50);
    conv_check("dot_edge", 'hC00);
    goto_px(120, 0);
    conv_check("blank", 'h000);

    // Abort after 7 falls, then a full conversion
    goto_px(3, 7);
    mode_s = 2'd0;
    const_value = 12'h3C9;
    run_conv(7, w);
    check_eq("abort_bits", 32'(w[6:0]), 32'(16'h03C9 >> 9));
    cs_n = 1'b1;
    tick(HALF);
    check_eq("abort_oe", 32'(sdata_oe), 32'd0);
    check_eq("abort_cnt", 32'(conv_count), 32'(m_conv));
    conv_check("post_abort", 'h3C9);

    // Reset mid-shift with cs_n held low
    run_conv(5, w);
    rst_n = 1'b0;
    #1;
    m_row = 0;
    m_col = 0;
    m_conv = 0;
    check_eq("mid_rst_oe", 32'(sdata_oe), 32'd0);
    check_eq("mid_rst_cnt", 32'(conv_count), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(HALF);
    for (int k = 0; k < 3; k++) begin
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
      tick(HALF);
    end
    check_eq("post_rst_oe", 32'(sdata_oe), 32'd0);
    cs_n = 1'b1;
    tick(HALF);
    check_eq("post_rst_idle", 32'(sdata_oe), 32'd0);
    const_value = 12'h5A1;
    conv_check("post_rst_conv", 'h5A1);

    // Randomized conversions against the model
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse(2);
        pulse(0);
      end
      nr = $urandom_range(0, 40);
      nc = $urandom_range(0, 40);
      repeat (nr) pulse(3);
      repeat (nc) pulse(1);
      md = $urandom_range(0, 3);
      mode_s = 2'(md);
      const_value = 12'($urandom);
      dot_row = 7'($urandom);
      dot_col = 7'($urandom);
      dot_r2 = 14'($urandom_range(0, 6000));
      check_eq("rnd_row", 32'(cur_row), 32'(m_row));
      check_eq("rnd_col", 32'(cur_col), 32'(m_col));
      ev = pixel(m_row, m_col, md, int'(const_value), int'(dot_row), int'(dot_col),
                 int'(dot_r2));
      if ($urandom_range(0, 4) == 0) begin
        nf = $urandom_range(1, 15);
        run_conv(nf, w);
        cs_n = 1'b1;
        tick(HALF);
        check_eq("rnd_abort_cnt", 32'(conv_count), 32'(m_conv));
      end
      conv_check("rnd_conv", ev);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_emulator.md
# adc_emulator

- Synthesizable responder for the imager's serial ADC link: stands in for the Stonyman sensor plus its 12-bit serial ADC on one camera channel, for hardware-in-the-loop bring-up without a sensor.
- Tracks row/column pointers from the Stonyman control pins, then serves a programmable test-pattern pixel on each ADC conversion (cs_n/sclk framing, data on sdata).
- Sits in place of the off-chip devices, directly on a camera channel's sclk, cs_n, resp, incp, resv, incv, inphi and sdata nets.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on every pin input (min 2).
- IMG_DIM, 112: active rows/cols; pointers outside this range return blank pixel 12'h000.
- LFSR_SEED, 16'hACE1: noise LFSR reset value (used only with ADC_EMU_NOISE_EN).

Ports (direction, width, meaning):
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sclk  in  1  ADC serial clock from the controller.
- cs_n  in  1  ADC chip select, active low.
- resp  in  1  column pointer reset, level-active high.
- incp  in  1  column increment on rising edge.
- resv  in  1  row pointer reset, level-active high.
- incv  in  1  row increment on rising edge.
- inphi  in  1  accepted; ignored.
- mode  in  2  pattern select.
- const_value  in  12  mode-0 value.
- dot_row  in  7  mode-3 dot centre row.
- dot_col  in  7  mode-3 dot centre column.
- dot_r2  in  14  mode-3 squared radius.
- sdata  out  1  serial ADC data.
- sdata_oe  out  1  high while the emulated ADC drives sdata.
- cur_row  out  7  current row pointer.
- cur_col  out  7  current column pointer.
- conv_count  out  16  completed conversions; wraps at 16'hFFFF→0.

## Operation
- All pin inputs pass SYNC_STAGES flops, then one edge-detect register.

Pointers:
- Synced resp high: col=0.
- incp rising: col+1, 7-bit wrap 127→0. Rows behave identically with resv/incv.
- Reset level beats a simultaneous increment edge.

Pattern value, evaluated from the current pointers at the synced cs_n falling edge:
- mode 0: const_value.
- mode 1: {col,5'b0}.
- mode 2: 12'hFFF if row[3]^col[3], else 12'h000.
- mode 3: 12'h100 if (row−dot_row)²+(col−dot_col)² < dot_r2, else 12'hC00. Differences are signed 8-bit; squares 14-bit; sum 15-bit unsigned.

FSM states IDLE, SHIFT, TAIL:
- IDLE: sdata_oe=0, sdata=0. On synced cs_n fall: load shift register {4'b0000, value}, sdata=bit15, sdata_oe=1, bit_cnt=0, go to SHIFT.
- SHIFT: on each synced sclk falling edge, shift left and increment bit_cnt. After the 15th falling edge, bit 0 (pixel LSB) is presented. The 16th falling edge goes to TAIL with sdata=0 and increments conv_count.
- TAIL: sdata=0, sdata_oe=1, until cs_n rises.
- Any state: synced cs_n rise goes to IDLE. If this happens before the 16th edge (abort), conv_count is unchanged.
- sclk edges while in IDLE are ignored.

## Timing
- Reset values: sdata=0, sdata_oe=0, cur_row=0, cur_col=0, conv_count=0; FSM in IDLE.
- Pin-to-action latency is SYNC_STAGES+1 cycles (3 at default) for every input edge. The same latency applies from sclk fall to the sdata update.
- Pixel value is sampled in the same cycle the FSM leaves IDLE; later pointer changes do not affect the conversion in flight.
- Constraint on the controller: sclk high and low times ≥ SYNC_STAGES+2 clk cycles. Faster sclk is unsupported (edges may be missed).
- Reset asserted mid-conversion: immediate return to reset values. After release, a cs_n already low is not treated as a new fall; the next conversion starts only on a fresh fall.

## Configuration
- ADC_EMU_NOISE_EN defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11), seeded with LFSR_SEED, advances once per conversion start.
  - Its low 4 bits are XORed into value[3:0] before load.
- Undefined: no LFSR; patterns are exact.

## Structure
- Shared package adc_emu_pkg:
  - mode encodings (MODE_CONST, MODE_RAMP, MODE_CHECK, MODE_DOT), FSM state enum, ADC frame constants (LEAD_BITS=4, DATA_BITS=12), blank and dot level constants.
- Sub-module adc_emu_pattern:
  - combinational pattern generator (pointers + mode → 12-bit value), including the mode-3 distance arithmetic.
  - Keeps the top to synchronizers, pointers and FSM.

## Test plan
- Reset, then mode 0, const_value=12'hA5C, one 16-sclk conversion → sdata bits 0000_1010_0101_1100 MSB first; conv_count=1; sdata_oe low 3 clk after cs_n rises.
- resv/resp pulse, 5 incv and 9 incp rising edges, mode 1 conversion → cur_row=5, cur_col=9, data 12'h120.
- resp held high while incp pulses → cur_col stays 0; 128 incp pulses from 0 → cur_col wraps to 0.
- Mode 3, dot (50,50), dot_r2=100: pixel (52,53) → 12'h100; pixel (60,50) → 12'hC00; pixel (120,0) → 12'h000.
- cs_n raised after 7 sclk falls → FSM IDLE, conv_count unchanged; next full conversion returns the correct full value.
- reset asserted mid-SHIFT with cs_n held low, then released → sdata_oe stays 0 until cs_n rises and falls again.
